// File: rtl/seven_seg_scan_driver.sv
// Multiplexed N-digit seven-segment driver: shadow/display BCD registers, guarded digit scan, LZ suppression, blanking, DP.
// Latency: outputs registered, 1 cycle behind scan state. No backpressure. Optional hex glyphs: SEVEN_SEG_HEX_EN.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int GUARD          = 2,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_en,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic [IW-1:0]           scan_idx,
  output logic                    frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] shadow, display;
  logic [NUM_DIGITS-1:0]   dp_shadow, dp_display;
  logic                    last_cnt, boundary;

  assign last_cnt = (cnt == CW'(SCAN_DIV - 1));
  assign boundary = last_cnt && (idx == IW'(NUM_DIGITS - 1));

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0: s = 7'b1111110;
      4'd1: s = 7'b0110000;
      4'd2: s = 7'b1101101;
      4'd3: s = 7'b1111001;
      4'd4: s = 7'b0110011;
      4'd5: s = 7'b1011011;
      4'd6: s = 7'b1011111;
      4'd7: s = 7'b1110000;
      4'd8: s = 7'b1111111;
      4'd9: s = 7'b1111011;
`ifdef SEVEN_SEG_HEX_EN
      4'd10: s = 7'b1110111;
      4'd11: s = 7'b0011111;
      4'd12: s = 7'b1001110;
      4'd13: s = 7'b0111101;
      4'd14: s = 7'b1001111;
      4'd15: s = 7'b1000111;
`endif
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (last_cnt) begin
      cnt <= '0;
      idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Display reloads only at the frame boundary so a frame never mixes old and new digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow     <= '0;
      dp_shadow  <= '0;
      display    <= '0;
      dp_display <= '0;
    end else begin
      if (load) begin
        shadow    <= digits_in;
        dp_shadow <= dp_in;
      end
      if (boundary) begin
        display    <= shadow;
        dp_display <= dp_shadow;
      end
    end
  end

  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  all_zero;

  // lead_zero[k]: nibbles k..top are all zero (digit 0 is never suppressed).
  always_comb begin
    all_zero  = 1'b1;
    lead_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nib[k]   = display[4*k +: 4];
      all_zero = all_zero & (nib[k] == 4'd0);
      if (k != 0) lead_zero[k] = all_zero;
    end
  end

  logic                  dark;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;
  logic [NUM_DIGITS-1:0] den_nxt;

  always_comb begin
    dark    = blank_mask[idx] | (lz_en & lead_zero[idx]);
    seg_nxt = dark ? 7'b0000000 : decode(nib[idx]);
    dp_nxt  = ~dark & dp_display[idx];
    den_nxt = '0;
    if (cnt >= CW'(GUARD)) den_nxt[idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_out    <= SEG_OFF;
      dp_out     <= DP_OFF;
      digit_en   <= DIG_OFF;
      scan_idx   <= '0;
      frame_done <= 1'b0;
    end else begin
      seg_out    <= seg_nxt ^ SEG_OFF;
      dp_out     <= dp_nxt ^ DP_OFF;
      digit_en   <= den_nxt ^ DIG_OFF;
      scan_idx   <= idx;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: NUM_DIGITS=4, SCAN_DIV=8, GUARD=2, plus an active-low-output instance.
module tb_seven_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic [3:0]  blank_mask = '0;
  logic        lz_en = 1'b0;

  logic [6:0] seg_out, seg2;
  logic       dp_out, dp2;
  logic [3:0] digit_en, den2;
  logic [1:0] scan_idx, idx2;
  logic       frame_done, fd2;

  int n_checks = 0;
  int n_fail   = 0;
  int pos      = 0;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(8), .GUARD(2),
                          .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load),
    .blank_mask(blank_mask), .lz_en(lz_en), .seg_out(seg_out), .dp_out(dp_out),
    .digit_en(digit_en), .scan_idx(scan_idx), .frame_done(frame_done));

  seven_seg_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(8), .GUARD(2),
                          .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load),
    .blank_mask(blank_mask), .lz_en(lz_en), .seg_out(seg2), .dp_out(dp2),
    .digit_en(den2), .scan_idx(idx2), .frame_done(fd2));

  // pos counts falling edges since the reference edge that started a frame;
  // outputs for (digit d, cnt c) are visible at pos = 8*d + c + 1.
  task automatic goto_slot(input int d, input int c);
    int target;
    target = 8*d + c + 1;
    while (pos < target) begin
      @(negedge clk);
      pos++;
    end
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 100);
    n_checks++;
    if (frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_frame: frame_done=%b after %0d cycles, required 1", frame_done, n);
    end
    pos = 0;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    digits_in = d;
    dp_in     = p;
    load      = 1'b1;
    @(negedge clk);
    pos++;
    load      = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    @(negedge clk);
    n_checks++;
    if (seg_out !== 7'b0000000 || dp_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_seg: seg=%b dp=%b, required 0000000 0", seg_out, dp_out);
    end
    n_checks++;
    if (digit_en !== 4'b0000 || frame_done !== 1'b0 || scan_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_ctl: en=%b fd=%b idx=%0d, required 0000 0 0", digit_en, frame_done, scan_idx);
    end
    n_checks++;
    if (seg2 !== 7'b1111111 || dp2 !== 1'b1 || den2 !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_active_low: seg=%b dp=%b en=%b, required 1111111 1 1111", seg2, dp2, den2);
    end
    rst = 1'b0;
    n = 0;
    while (!frame_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n !== 32) begin
      n_fail++;
      $display("FAIL first_frame_done: %0d cycles after reset release, required 32", n);
    end
    pos = 0;
    @(negedge clk);
    pos++;
    n_checks++;
    if (frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_done_width: frame_done=%b one cycle later, required 0", frame_done);
    end
  endtask

  task automatic test_scan_1234();
    int on_cnt;
    do_load(16'h1234, 4'b0000);
    wait_frame();
    goto_slot(0, 0);
    n_checks++;
    if (seg_out !== 7'b0110011 || digit_en !== 4'b0000 || scan_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL slot0_guard: seg=%b en=%b idx=%0d, required 0110011 0000 0", seg_out, digit_en, scan_idx);
    end
    on_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      goto_slot(0, c);
      if (digit_en == 4'b0001) on_cnt++;
    end
    n_checks++;
    if (on_cnt !== 6) begin
      n_fail++;
      $display("FAIL slot0_enable_cycles: %0d cycles of 0001, required 6", on_cnt);
    end
    goto_slot(1, 4);
    n_checks++;
    if (seg_out !== 7'b1111001 || digit_en !== 4'b0010) begin
      n_fail++;
      $display("FAIL slot1_digit3: seg=%b en=%b, required 1111001 0010", seg_out, digit_en);
    end
    goto_slot(2, 4);
    n_checks++;
    if (seg_out !== 7'b1101101 || dp_out !== 1'b0) begin
      n_fail++;
      $display("FAIL slot2_digit2: seg=%b dp=%b, required 1101101 0", seg_out, dp_out);
    end
    goto_slot(3, 4);
    n_checks++;
    if (seg_out !== 7'b0110000 || digit_en !== 4'b1000 || scan_idx !== 2'd3) begin
      n_fail++;
      $display("FAIL slot3_digit1: seg=%b en=%b idx=%0d, required 0110000 1000 3", seg_out, digit_en, scan_idx);
    end
  endtask

  task automatic test_leading_zero();
    wait_frame();
    lz_en = 1'b1;
    do_load(16'h0070, 4'b1010);
    wait_frame();
    goto_slot(0, 4);
    n_checks++;
    if (seg_out !== 7'b1111110 || dp_out !== 1'b0) begin
      n_fail++;
      $display("FAIL lz_digit0: seg=%b dp=%b, required 1111110 0", seg_out, dp_out);
    end
    goto_slot(1, 4);
    n_checks++;
    if (seg_out !== 7'b1110000 || dp_out !== 1'b1) begin
      n_fail++;
      $display("FAIL lz_digit1: seg=%b dp=%b, required 1110000 1", seg_out, dp_out);
    end
    goto_slot(2, 4);
    n_checks++;
    if (seg_out !== 7'b0000000 || digit_en !== 4'b0100) begin
      n_fail++;
      $display("FAIL lz_digit2_dark: seg=%b en=%b, required 0000000 0100", seg_out, digit_en);
    end
    goto_slot(3, 4);
    n_checks++;
    if (seg_out !== 7'b0000000 || dp_out !== 1'b0) begin
      n_fail++;
      $display("FAIL lz_digit3_dark: seg=%b dp=%b, required 0000000 0", seg_out, dp_out);
    end
    wait_frame();
    lz_en = 1'b0;
    goto_slot(3, 4);
    n_checks++;
    if (seg_out !== 7'b1111110 || dp_out !== 1'b1) begin
      n_fail++;
      $display("FAIL nolz_digit3: seg=%b dp=%b, required 1111110 1", seg_out, dp_out);
    end
  endtask

  task automatic test_boundary_load();
    wait_frame();
    do_load(16'h1111, 4'b0000);
    wait_frame();
    goto_slot(3, 6);
    digits_in = 16'h9999;
    load      = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n_checks++;
    if (frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL boundary_alignment: frame_done=%b, required 1", frame_done);
    end
    pos = 0;
    goto_slot(0, 3);
    n_checks++;
    if (seg_out !== 7'b0110000) begin
      n_fail++;
      $display("FAIL boundary_old_value: seg=%b, required 0110000", seg_out);
    end
    wait_frame();
    goto_slot(0, 3);
    n_checks++;
    if (seg_out !== 7'b1111011) begin
      n_fail++;
      $display("FAIL boundary_new_value: seg=%b, required 1111011", seg_out);
    end
    goto_slot(3, 3);
    n_checks++;
    if (seg_out !== 7'b1111011) begin
      n_fail++;
      $display("FAIL boundary_new_digit3: seg=%b, required 1111011", seg_out);
    end
  endtask

  task automatic test_hex_and_polarity();
    logic [6:0] exp_b;
`ifdef SEVEN_SEG_HEX_EN
    exp_b = 7'b0011111;
`else
    exp_b = 7'b0000000;
`endif
    wait_frame();
    do_load(16'h000B, 4'b0000);
    wait_frame();
    goto_slot(0, 3);
    n_checks++;
    if (seg_out !== exp_b) begin
      n_fail++;
      $display("FAIL hex_b: seg=%b, required %b", seg_out, exp_b);
    end
    n_checks++;
    if (seg2 !== ~exp_b) begin
      n_fail++;
      $display("FAIL hex_b_active_low: seg=%b, required %b", seg2, ~exp_b);
    end
    goto_slot(1, 3);
    n_checks++;
    if (seg2 !== 7'b0000001 || den2 !== 4'b1101) begin
      n_fail++;
      $display("FAIL active_low_digit1: seg=%b en=%b, required 0000001 1101", seg2, den2);
    end
  endtask

  task automatic test_reset_midscan();
    wait_frame();
    blank_mask = 4'b0001;
    goto_slot(2, 3);
    rst = 1'b1;
    #1;
    n_checks++;
    if (seg_out !== 7'b0000000 || digit_en !== 4'b0000 || scan_idx !== 2'd0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midscan_async_reset: seg=%b en=%b idx=%0d fd=%b, required 0000000 0000 0 0",
               seg_out, digit_en, scan_idx, frame_done);
    end
    n_checks++;
    if (seg2 !== 7'b1111111 || den2 !== 4'b1111) begin
      n_fail++;
      $display("FAIL midscan_reset_active_low: seg=%b en=%b, required 1111111 1111", seg2, den2);
    end
    @(negedge clk);
    rst = 1'b0;
    pos = 0;
    goto_slot(0, 0);
    n_checks++;
    if (scan_idx !== 2'd0 || digit_en !== 4'b0000) begin
      n_fail++;
      $display("FAIL restart_idx: idx=%0d en=%b, required 0 0000", scan_idx, digit_en);
    end
    goto_slot(0, 3);
    n_checks++;
    if (seg_out !== 7'b0000000 || dp_out !== 1'b0 || digit_en !== 4'b0001) begin
      n_fail++;
      $display("FAIL blank_digit0: seg=%b dp=%b en=%b, required 0000000 0 0001", seg_out, dp_out, digit_en);
    end
    goto_slot(1, 3);
    n_checks++;
    if (seg_out !== 7'b1111110 || digit_en !== 4'b0010) begin
      n_fail++;
      $display("FAIL unblanked_digit1: seg=%b en=%b, required 1111110 0010", seg_out, digit_en);
    end
  endtask

  initial begin
    test_reset();
    test_scan_1234();
    test_leading_zero();
    test_boundary_load();
    test_hex_and_polarity();
    test_reset_midscan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
